fft_bitrev_reorder: RTL and testbench

//  Converts the serial, bit-reversed-order FFT output stream into natural order (X[0]..X[N-1]).

---
 rtl/fft_bitrev_reorder.sv | 124 ++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Reorders a serial bit-reversed FFT frame stream into natural bin order
// using two ping-pong frame banks: one is filled while the other is read out.
module fft_bitrev_reorder #(
  parameter int DW    = 32,
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    din_re,
  input  logic [DW-1:0]    din_im,
  input  logic             din_valid,
  output logic [DW-1:0]    dout_re,
  output logic [DW-1:0]    dout_im,
  output logic             dout_valid,
  output logic [LOG2N-1:0] dout_index,
  output logic             dout_first,
  output logic             dout_last
);

  localparam int N = 1 << LOG2N;

  typedef enum logic {IDLE, READ} rd_state_t;

  logic [2*DW-1:0]  mem [0:2*N-1];
  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic             frame_done;

  rd_state_t        state, state_next;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_next;
  logic             rd_bank, rd_bank_next;
  logic             req_pend, req_pend_next;
  logic             rd_en;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign frame_done = din_valid && (&wr_cnt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (din_valid) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (&wr_cnt) wr_bank <= ~wr_bank;
    end
  end

  // Bank RAM is deliberately not reset; a restarted frame simply overwrites it.
  always_ff @(posedge clk) begin
    if (rst && din_valid) mem[{wr_bank, bitrev(wr_cnt)}] <= {din_re, din_im};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      req_pend <= 1'b0;
    end else begin
      state    <= state_next;
      rd_cnt   <= rd_cnt_next;
      rd_bank  <= rd_bank_next;
      req_pend <= req_pend_next;
    end
  end

  // A finished frame leaves a pending request; at the end of a readout a
  // pending request chains straight into the other bank with no idle cycle.
  always_comb begin
    state_next    = state;
    rd_cnt_next   = rd_cnt;
    rd_bank_next  = rd_bank;
    req_pend_next = req_pend | frame_done;
    rd_en         = 1'b0;
    case (state)
      IDLE: begin
        if (req_pend) begin
          state_next    = READ;
          rd_cnt_next   = '0;
          rd_bank_next  = ~wr_bank;
          req_pend_next = frame_done;
        end
      end
      READ: begin
        rd_en       = 1'b1;
        rd_cnt_next = rd_cnt + 1'b1;
        if (&rd_cnt) begin
          if (req_pend || frame_done) begin
            rd_bank_next  = ~rd_bank;
            req_pend_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_re    <= '0;
      dout_im    <= '0;
      dout_valid <= 1'b0;
      dout_index <= '0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      dout_first <= rd_en && (rd_cnt == '0);
      dout_last  <= rd_en && (&rd_cnt);
      if (rd_en) begin
        {dout_re, dout_im} <= mem[{rd_bank, rd_cnt}];
        dout_index         <= rd_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed self-checking bench for fft_bitrev_reorder: latency, ordering,
// gapped input, back-to-back banks, resets mid-frame and mid-readout.
module tb_fft_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din_re, din_im;
  logic        din_valid;
  logic [31:0] dout_re, dout_im;
  logic        dout_valid;
  logic [5:0]  dout_index;
  logic        dout_first, dout_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] qRe[$], qIm[$];
  int          qIdx[$], qFirst[$], qLast[$], qCyc[$];

  fft_bitrev_reorder #(.DW(32), .LOG2N(6)) dut (
    .clk(clk), .rst(rst),
    .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
    .dout_re(dout_re), .dout_im(dout_im), .dout_valid(dout_valid),
    .dout_index(dout_index), .dout_first(dout_first), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every valid output sample together with the edge count it appeared after.
  always @(negedge clk) begin
    if (dout_valid) begin
      qRe.push_back(dout_re);
      qIm.push_back(dout_im);
      qIdx.push_back(int'(dout_index));
      qFirst.push_back(int'(dout_first));
      qLast.push_back(int'(dout_last));
      qCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int tbBitrev(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 6; i++) begin
      r = (r << 1) | (x & 1);
      x = x >> 1;
    end
    return r;
  endfunction

  task automatic clearQueues();
    qRe.delete(); qIm.delete(); qIdx.delete();
    qFirst.delete(); qLast.delete(); qCyc.delete();
  endtask

  task automatic applyStimulus(input int base, input bit gaps, input bit special,
                               input int count, output int storeCyc);
    for (int k = 0; k < count; k++) begin
      if (gaps && k > 0) begin
        @(negedge clk);
        din_valid = 1'b0;
      end
      @(negedge clk);
      din_valid = 1'b1;
      din_re    = 32'(base + k);
      din_im    = -32'(base + k);
      if (special && k == 1) begin
        din_re = 32'h7FFF_FFFF;
        din_im = 32'h8000_0000;
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    storeCyc  = cyc;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic verifyFrames(input string tag, input int nFrames, input int base, input int startCyc);
    int total = nFrames * 64;
    int budget = total + 60;
    while (qRe.size() < total && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput({tag, "_count"}, 32'(qRe.size()), 32'(total));
    if (qRe.size() >= total) begin
      checkOutput({tag, "_start"}, 32'(qCyc[0]), 32'(startCyc));
      for (int j = 0; j < total; j++) begin
        int b = j % 64;
        logic [31:0] e = 32'(base + (j / 64) * 64 + tbBitrev(b));
        checkOutput($sformatf("%s_re%0d", tag, j), qRe[j], e);
        checkOutput($sformatf("%s_im%0d", tag, j), qIm[j], -e);
        checkOutput($sformatf("%s_idx%0d", tag, j), 32'(qIdx[j]), 32'(b));
        checkOutput($sformatf("%s_first%0d", tag, j), 32'(qFirst[j]), 32'(b == 0));
        checkOutput($sformatf("%s_last%0d", tag, j), 32'(qLast[j]), 32'(b == 63));
        checkOutput($sformatf("%s_cyc%0d", tag, j), 32'(qCyc[j]), 32'(qCyc[0] + j));
      end
    end
    repeat (20) @(negedge clk);
    checkOutput({tag, "_noextra"}, 32'(qRe.size()), 32'(total));
  endtask

  initial begin
    int storeCyc;
    int budget;
    int handRe[8] = '{0, 32, 16, 48, 8, 40, 24, 56};

    rst = 1'b0; din_valid = 1'b0; din_re = '0; din_im = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_re", dout_re, 32'd0);
    checkOutput("rst_im", dout_im, 32'd0);
    checkOutput("rst_idx", 32'(dout_index), 32'd0);
    checkOutput("rst_first", 32'(dout_first), 32'd0);
    checkOutput("rst_last", 32'(dout_last), 32'd0);
    rst = 1'b1;

    $display("[TB] test 1: contiguous frame");
    clearQueues();
    applyStimulus(0, 1'b0, 1'b0, 64, storeCyc);
    verifyFrames("t1", 1, 0, storeCyc + 2);
    if (qRe.size() >= 64) begin
      for (int i = 0; i < 8; i++) checkOutput($sformatf("t1_hand%0d", i), qRe[i], 32'(handRe[i]));
      checkOutput("t1_hand63", qRe[63], 32'd63);
    end

    $display("[TB] test 2: gapped input");
    clearQueues();
    applyStimulus(0, 1'b1, 1'b0, 64, storeCyc);
    verifyFrames("t2", 1, 0, storeCyc + 2);

    $display("[TB] test 3: three back-to-back frames");
    clearQueues();
    applyStimulus(1000, 1'b0, 1'b0, 192, storeCyc);
    verifyFrames("t3", 3, 1000, storeCyc + 2 - 128);

    $display("[TB] test 4: reset mid-frame");
    clearQueues();
    applyStimulus(5000, 1'b0, 1'b0, 20, storeCyc);
    resetPulse();
    clearQueues();
    applyStimulus(300, 1'b0, 1'b0, 64, storeCyc);
    verifyFrames("t4", 1, 300, storeCyc + 2);

    $display("[TB] test 5: reset mid-readout");
    clearQueues();
    applyStimulus(400, 1'b0, 1'b0, 64, storeCyc);
    budget = 200;
    while (!(dout_valid && dout_index == 6'd10) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("t5_reach10", 32'(budget > 0), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_valid", 32'(dout_valid), 32'd0);
    checkOutput("t5_re", dout_re, 32'd0);
    checkOutput("t5_im", dout_im, 32'd0);
    checkOutput("t5_idx", 32'(dout_index), 32'd0);
    checkOutput("t5_first", 32'(dout_first), 32'd0);
    checkOutput("t5_last", 32'(dout_last), 32'd0);
    rst = 1'b1;
    clearQueues();
    applyStimulus(600, 1'b0, 1'b0, 64, storeCyc);
    verifyFrames("t5", 1, 600, storeCyc + 2);

    $display("[TB] test 6: extreme values at input position 1");
    clearQueues();
    applyStimulus(0, 1'b0, 1'b1, 64, storeCyc);
    budget = 150;
    while (qRe.size() < 64 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("t6_count", 32'(qRe.size()), 32'd64);
    if (qRe.size() >= 64) begin
      checkOutput("t6_re32", qRe[32], 32'h7FFF_FFFF);
      checkOutput("t6_im32", qIm[32], 32'h8000_0000);
      checkOutput("t6_idx32", 32'(qIdx[32]), 32'd32);
      checkOutput("t6_re0", qRe[0], 32'd0);
      checkOutput("t6_re31", qRe[31], 32'd62);
      checkOutput("t6_im31", qIm[31], -32'd62);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
